// File: rtl/fpu_add_arbiter.sv
// Round-robin sharing of one multi-cycle FP32 adder; one op in flight, response one cycle after fpu_ready.
// Requests wait (held valid) until IDLE; FPU_ARB_TIMEOUT_EN adds a WAIT_RES watchdog returning qNaN with rsp_err.
module fpu_add_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [32*NUM_REQ-1:0]  req_a,
  input  logic [32*NUM_REQ-1:0]  req_b,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic [31:0]            rsp_data,
  output logic                   rsp_err,
  output logic                   fpu_valid,
  output logic [31:0]            fpu_din1,
  output logic [31:0]            fpu_din2,
  input  logic [31:0]            fpu_result,
  input  logic                   fpu_ready
);

  localparam int IW = $clog2(NUM_REQ);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 2) begin : g_bad_params
    $error("fpu_add_arbiter: unsupported NUM_REQ or TIMEOUT");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RES, RESPOND} state_t;

  state_t          state;
  logic [IW-1:0]   last_grant;
  logic [IW-1:0]   grant;
  logic [IW-1:0]   pick;
  logic            found;
  logic [IW:0]     idx;

  // Search upward from the requester after the last one served, wrapping.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = {1'b0, last_grant} + (IW+1)'(i);
      if (idx >= (IW+1)'(NUM_REQ)) idx = idx - (IW+1)'(NUM_REQ);
      if (!found && req_valid[idx[IW-1:0]]) begin
        found = 1'b1;
        pick  = idx[IW-1:0];
      end
    end
  end

`ifdef FPU_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT);
  logic [CW-1:0] wd_cnt;
`else
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      last_grant <= IW'(NUM_REQ-1);
      grant      <= '0;
      req_ready  <= '0;
      rsp_valid  <= '0;
      rsp_data   <= '0;
      fpu_valid  <= 1'b0;
      fpu_din1   <= '0;
      fpu_din2   <= '0;
`ifdef FPU_ARB_TIMEOUT_EN
      rsp_err    <= 1'b0;
      wd_cnt     <= '0;
`endif
    end else begin
      req_ready <= '0;
      rsp_valid <= '0;
      fpu_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            grant     <= pick;
            fpu_din1  <= req_a[{pick, 5'b0} +: 32];
            fpu_din2  <= req_b[{pick, 5'b0} +: 32];
            req_ready <= ONE_HOT0 << pick;
            fpu_valid <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
`ifdef FPU_ARB_TIMEOUT_EN
          wd_cnt <= '0;
`endif
          state <= WAIT_RES;
        end
        WAIT_RES: begin
          if (fpu_ready) begin
            rsp_data  <= fpu_result;
            rsp_valid <= ONE_HOT0 << grant;
`ifdef FPU_ARB_TIMEOUT_EN
            rsp_err   <= 1'b0;
`endif
            state     <= RESPOND;
          end
`ifdef FPU_ARB_TIMEOUT_EN
          // Fires so the NaN response lands exactly TIMEOUT cycles after the issue cycle.
          else if (wd_cnt == CW'(TIMEOUT-2)) begin
            rsp_data  <= 32'h7FC0_0000;
            rsp_err   <= 1'b1;
            rsp_valid <= ONE_HOT0 << grant;
            state     <= RESPOND;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
`endif
        end
        RESPOND: begin
          last_grant <= grant;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_add_arbiter.sv
// Bench for fpu_add_arbiter: requester queues, FP32 adder stand-in, grant/response scoreboard.
module tb_fpu_add_arbiter;
  localparam int NR = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [NR-1:0]     req_valid;
  logic [32*NR-1:0]  req_a, req_b;
  logic [NR-1:0]     req_ready, rsp_valid;
  logic [31:0]       rsp_data;
  logic              rsp_err;
  logic              fpu_valid;
  logic [31:0]       fpu_din1, fpu_din2;
  logic [31:0]       fpu_result;
  logic              fpu_ready;

  always #5 clk = ~clk;

  fpu_add_arbiter #(.NUM_REQ(NR)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .fpu_valid(fpu_valid), .fpu_din1(fpu_din1), .fpu_din2(fpu_din2),
    .fpu_result(fpu_result), .fpu_ready(fpu_ready)
  );

  typedef struct { logic [31:0] a; logic [31:0] b; } op_t;
  typedef struct { int idx; logic [31:0] d; logic err; int cyc; } ev_t;
  typedef struct { int idx; logic [31:0] a; logic [31:0] b; int lat; logic [31:0] sum; } vec_t;

  op_t  rq [NR][$];
  ev_t  exp_q[$];
  ev_t  rsp_q[$];
  int   acc_q[$];
  int   iss_cyc_q[$];

  int   n_checks = 0, n_err = 0;
  int   cyc = 0, ready_cyc = 0, model_last = NR-1;
  int   pend = 0, fixed_lat = 3;
  logic [31:0] pend_sum;
  logic adder_on = 1'b1, stale_req = 1'b0;

  vec_t vecs[4];
  int   exp_order[5];
  int   n0, a0, i0, pushed;

  function automatic void check(string name, logic [31:0] act, logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, expv);
    end
  endfunction

  // Positive-normal FP32 add with truncation: stand-in for the external adder.
  function automatic logic [31:0] fp32_add(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] t;
    logic [7:0]  ex, ey, e;
    logic [24:0] mx, my, s;
    if (x[30:23] < y[30:23]) begin t = x; x = y; y = t; end
    ex = x[30:23]; ey = y[30:23];
    mx = {2'b01, x[22:0]};
    my = {2'b01, y[22:0]} >> (ex - ey);
    s  = mx + my; e = ex;
    if (s[24]) begin s = s >> 1; e = e + 8'd1; end
    return {1'b0, e, s[22:0]};
  endfunction

  function automatic logic [31:0] rnd_fp();
    return {1'b0, 8'($urandom_range(110, 140)), 23'($urandom)};
  endfunction

  // Environment: requesters, adder stand-in and scoreboard, all on the falling edge.
  always @(negedge clk) begin
    int g, exp_g, j;
    op_t op;
    ev_t e, r;
    cyc++;
    if (!reset) begin
      exp_q.delete();
      pend = 0;
      fpu_ready = 1'b0;
      model_last = NR-1;
    end else begin
      if (req_ready != '0) begin
        check("req_ready one-hot", $countones(req_ready), 1);
        g = 0;
        for (int k = NR-1; k >= 0; k--) if (req_ready[k]) g = k;
        exp_g = NR;
        for (int k = 1; k <= NR; k++) begin
          j = (model_last + k) % NR;
          if (exp_g == NR && req_valid[j]) exp_g = j;
        end
        check("grant index", g, exp_g);
        check("single outstanding op", exp_q.size(), 0);
        check("granted requester had an op", rq[g].size() > 0, 1);
        if (rq[g].size() > 0) begin
          op = rq[g].pop_front();
          check("fpu_din1", fpu_din1, op.a);
          check("fpu_din2", fpu_din2, op.b);
          e.idx = g; e.cyc = cyc; e.err = !adder_on;
          e.d = adder_on ? fp32_add(op.a, op.b) : 32'h7FC0_0000;
          exp_q.push_back(e);
        end
        acc_q.push_back(g);
      end
      if (fpu_valid) begin
        check("issue paired with accept", req_ready != '0, 1);
        iss_cyc_q.push_back(cyc);
      end
      if (rsp_valid != '0) begin
        check("rsp_valid one-hot", $countones(rsp_valid), 1);
        g = 0;
        for (int k = NR-1; k >= 0; k--) if (rsp_valid[k]) g = k;
        if (exp_q.size() == 0) check("response without op", rsp_valid, 0);
        else begin
          e = exp_q.pop_front();
          check("response requester", g, e.idx);
          check("rsp_data", rsp_data, e.d);
          check("rsp_err", rsp_err, e.err);
          if (!e.err) check("response one cycle after fpu_ready", cyc - ready_cyc, 1);
        end
        model_last = g;
        r.idx = g; r.d = rsp_data; r.err = rsp_err; r.cyc = cyc;
        rsp_q.push_back(r);
      end
      fpu_ready = 1'b0;
      if (stale_req) begin
        fpu_ready = 1'b1; fpu_result = 32'hDEAD_BEEF; stale_req = 1'b0; ready_cyc = cyc;
      end
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin fpu_ready = 1'b1; fpu_result = pend_sum; ready_cyc = cyc; end
      end
      if (fpu_valid && adder_on) begin
        pend = (fixed_lat > 0) ? fixed_lat : $urandom_range(1, 6);
        pend_sum = fp32_add(fpu_din1, fpu_din2);
      end
    end
    for (int k = 0; k < NR; k++) begin
      req_valid[k] = rq[k].size() > 0;
      if (rq[k].size() > 0) begin
        req_a[32*k +: 32] = rq[k][0].a;
        req_b[32*k +: 32] = rq[k][0].b;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push(input int i, input logic [31:0] a, input logic [31:0] b);
    op_t op;
    op.a = a; op.b = b;
    rq[i].push_back(op);
  endtask

  task automatic wait_rsp(input int n, input string name);
    int k;
    k = 0;
    while (rsp_q.size() < n && k < 600) begin tick(1); k++; end
    check(name, rsp_q.size() >= n, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
    fpu_ready = 1'b0; fpu_result = '0;
    vecs[0] = '{0, 32'h3F80_0000, 32'h4000_0000, 3, 32'h4040_0000};
    vecs[1] = '{1, 32'h4000_0000, 32'h4000_0000, 1, 32'h4080_0000};
    vecs[2] = '{2, 32'h4040_0000, 32'h3F80_0000, 5, 32'h4080_0000};
    vecs[3] = '{3, 32'h40A0_0000, 32'h4040_0000, 2, 32'h4100_0000};
    exp_order = '{0, 1, 2, 3, 0};

    repeat (2) @(posedge clk);
    #1;
    check("reset req_ready", req_ready, 0);
    check("reset rsp_valid", rsp_valid, 0);
    check("reset rsp_data", rsp_data, 0);
    check("reset rsp_err", rsp_err, 0);
    check("reset fpu_valid", fpu_valid, 0);
    check("reset fpu_din1", fpu_din1, 0);
    check("reset fpu_din2", fpu_din2, 0);
    reset = 1'b1;
    tick(2);

    // Single operations from the vector table.
    for (int v = 0; v < 4; v++) begin
      n0 = rsp_q.size(); a0 = acc_q.size(); i0 = iss_cyc_q.size();
      fixed_lat = vecs[v].lat;
      push(vecs[v].idx, vecs[v].a, vecs[v].b);
      wait_rsp(n0 + 1, "vector response arrives");
      if (rsp_q.size() > n0 && acc_q.size() > a0 && iss_cyc_q.size() > i0) begin
        check("vector accept index", acc_q[a0], vecs[v].idx);
        check("vector rsp index", rsp_q[n0].idx, vecs[v].idx);
        check("vector rsp data", rsp_q[n0].d, vecs[v].sum);
        check("vector issue-to-response cycles", rsp_q[n0].cyc - iss_cyc_q[i0], vecs[v].lat + 1);
      end
      tick(2);
    end

    // Contention: all requesters at once.
    n0 = rsp_q.size(); a0 = acc_q.size(); fixed_lat = 2;
    push(0, 32'h3F80_0000, 32'h3F80_0000);
    push(0, 32'h4100_0000, 32'h3F80_0000);
    push(1, 32'h4000_0000, 32'h3F80_0000);
    push(2, 32'h4040_0000, 32'h4040_0000);
    push(3, 32'h40A0_0000, 32'h4000_0000);
    wait_rsp(n0 + 5, "contention responses arrive");
    if (acc_q.size() >= a0 + 5)
      for (int k = 0; k < 5; k++) check("contention accept order", acc_q[a0+k], exp_order[k]);
    tick(2);

    // Rotation: after 2 is served, 1 and 3 together -> 3 first.
    n0 = rsp_q.size();
    push(2, 32'h3F80_0000, 32'h4000_0000);
    wait_rsp(n0 + 1, "rotation setup response");
    tick(2);
    a0 = acc_q.size();
    push(1, 32'h4000_0000, 32'h4000_0000);
    push(3, 32'h4040_0000, 32'h4000_0000);
    wait_rsp(n0 + 3, "rotation responses arrive");
    if (acc_q.size() >= a0 + 2) begin
      check("rotation first grant", acc_q[a0], 3);
      check("rotation second grant", acc_q[a0+1], 1);
    end
    tick(3);

    // Stale fpu_ready while idle.
    n0 = rsp_q.size();
    stale_req = 1'b1;
    tick(6);
    check("stale fpu_ready gives no response", rsp_q.size(), n0);

    // Withdrawn request while busy.
    n0 = rsp_q.size(); a0 = acc_q.size(); fixed_lat = 12;
    push(0, 32'h4000_0000, 32'h3F80_0000);
    tick(3);
    push(1, 32'h4100_0000, 32'h4100_0000);
    tick(3);
    rq[1].delete();
    wait_rsp(n0 + 1, "withdraw response arrives");
    tick(6);
    check("withdrawn request never accepted", acc_q.size(), a0 + 1);

    // Reset mid-operation.
    fixed_lat = 2; n0 = rsp_q.size();
    push(0, 32'h3F80_0000, 32'h3F80_0000);
    wait_rsp(n0 + 1, "pre-reset response");
    tick(2);
    fixed_lat = 20; i0 = iss_cyc_q.size();
    push(1, 32'h4040_0000, 32'h4040_0000);
    tick(6);
    check("op in flight before reset", iss_cyc_q.size(), i0 + 1);
    n0 = rsp_q.size();
    reset = 1'b0;
    #1;
    check("mid-op reset req_ready", req_ready, 0);
    check("mid-op reset rsp_valid", rsp_valid, 0);
    check("mid-op reset rsp_data", rsp_data, 0);
    check("mid-op reset fpu_valid", fpu_valid, 0);
    check("mid-op reset fpu_din1", fpu_din1, 0);
    check("mid-op reset fpu_din2", fpu_din2, 0);
    tick(3);
    reset = 1'b1;
    tick(25);
    check("dropped op gives no response", rsp_q.size(), n0);
    fixed_lat = 2; a0 = acc_q.size();
    push(1, 32'h4000_0000, 32'h3F80_0000);
    push(0, 32'h4040_0000, 32'h3F80_0000);
    wait_rsp(n0 + 2, "post-reset responses arrive");
    if (acc_q.size() >= a0 + 2) begin
      check("post-reset first grant", acc_q[a0], 0);
      check("post-reset second grant", acc_q[a0+1], 1);
    end
    tick(2);

    // Randomized traffic, random adder latency; scoreboard checks every event.
    fixed_lat = 0; n0 = rsp_q.size(); pushed = 0;
    for (int c = 0; c < 800; c++) begin
      int i;
      if ($urandom_range(0, 3) == 0) begin
        i = $urandom_range(0, NR-1);
        if (rq[i].size() < 2) begin push(i, rnd_fp(), rnd_fp()); pushed++; end
      end
      tick(1);
    end
    wait_rsp(n0 + pushed, "random traffic drains");
    check("random response count", rsp_q.size(), n0 + pushed);
    tick(3);

`ifdef FPU_ARB_TIMEOUT_EN
    adder_on = 1'b0; n0 = rsp_q.size(); i0 = iss_cyc_q.size();
    push(2, 32'h3F80_0000, 32'h3F80_0000);
    wait_rsp(n0 + 1, "timeout response arrives");
    if (rsp_q.size() > n0 && iss_cyc_q.size() > i0) begin
      check("timeout latency", rsp_q[n0].cyc - iss_cyc_q[i0], 64);
      check("timeout data", rsp_q[n0].d, 32'h7FC0_0000);
      check("timeout err", rsp_q[n0].err, 1);
    end
    tick(2);
    stale_req = 1'b1;
    tick(6);
    check("late fpu_ready ignored", rsp_q.size(), n0 + 1);
    adder_on = 1'b1; fixed_lat = 63; i0 = iss_cyc_q.size();
    push(1, 32'h4000_0000, 32'h3F80_0000);
    wait_rsp(n0 + 2, "boundary response arrives");
    if (rsp_q.size() > n0 + 1 && iss_cyc_q.size() > i0) begin
      check("boundary latency", rsp_q[n0+1].cyc - iss_cyc_q[i0], 64);
      check("boundary err", rsp_q[n0+1].err, 0);
      check("boundary data", rsp_q[n0+1].d, 32'h4040_0000);
    end
    tick(3);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/fpu_add_arbiter.md
Name: fpu_add_arbiter

Overview:
Round-robin arbiter and sequencer that shares one multi-cycle FP32 adder among NUM_REQ requesters. It accepts one operand pair at a time, issues it to the adder with a one-cycle valid pulse, and waits for the adder's one-cycle ready pulse. It then returns the sum to the granted requester on a per-requester response strobe. The block sits between the compute clients and the adder instance; only one operation is outstanding at any time.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
TIMEOUT, 64, watchdog limit in cycles; used only when FPU_ARB_TIMEOUT_EN is defined

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
req_valid  input  NUM_REQ  per-requester request; held with operands until accepted
req_a  input  32*NUM_REQ  operand A, requester i in bits [32i+31:32i]
req_b  input  32*NUM_REQ  operand B, same packing
req_ready  output  NUM_REQ  one-cycle accept pulse, one-hot
rsp_valid  output  NUM_REQ  one-cycle result strobe, one-hot
rsp_data  output  32  sum; held until the next response
rsp_err  output  1  timeout flag, qualified by rsp_valid; tied 0 without the macro
fpu_valid  output  1  one-cycle issue pulse to the adder
fpu_din1  output  32  operand A to the adder; held stable from ISSUE until the result returns
fpu_din2  output  32  operand B to the adder; same rule
fpu_result  input  32  adder result
fpu_ready  input  1  adder completion pulse

Behaviour:
- Reset (reset=0, asynchronous): state IDLE. All outputs are 0. last_grant = NUM_REQ-1, so requester 0 has first priority. The timeout counter is 0.
- FSM states: IDLE -> ISSUE -> WAIT_RES -> RESPOND -> IDLE.
- IDLE:
  - If any req_valid is set, pick the first set bit searching from last_grant+1 upward, wrapping modulo NUM_REQ.
  - Latch that requester's req_a/req_b into fpu_din1/fpu_din2, latch the grant index, and pulse req_ready[g] for this cycle only.
  - Go to ISSUE. If no request is pending, stay in IDLE.
- ISSUE: fpu_valid=1 for exactly one cycle. Clear the timeout counter. Go to WAIT_RES.
- WAIT_RES: wait for fpu_ready. On fpu_ready=1, capture fpu_result into rsp_data, set rsp_err=0, and go to RESPOND.
- RESPOND: rsp_valid[g]=1 for one cycle. Set last_grant=g. Go to IDLE.
- Latency: accept cycle, issue cycle, adder latency, then response one cycle after fpu_ready. Minimum request-to-request spacing is therefore adder latency + 3 cycles.
- fpu_ready seen in IDLE, ISSUE or RESPOND is ignored (stale pulse).
- A requester may drop req_valid before it is accepted; no side effect. Requests arriving during ISSUE, WAIT_RES or RESPOND wait for IDLE.
- Simultaneous requests: exactly one grant per accept cycle. req_ready and rsp_valid are always one-hot or zero.
- Reset mid-operation drops the operation: no rsp_valid is produced, and state returns to IDLE. The adder is reset from the same reset net.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,...,NUM_REQ-1,0.

Optional Feature:
FPU_ARB_TIMEOUT_EN
- Defined:
  - A counter increments each cycle in WAIT_RES.
  - If it reaches TIMEOUT without fpu_ready, go to RESPOND with rsp_data=32'h7FC00000 (quiet NaN) and rsp_err=1.
  - An fpu_ready arriving on the same cycle the counter reaches TIMEOUT wins: the real result is returned with rsp_err=0.
  - A late fpu_ready after a timeout is ignored.
- Not defined: no counter; WAIT_RES waits indefinitely and rsp_err is constant 0.

Test Plan:
- Single op: req_valid[0]=1, a=32'h3F800000, b=32'h40000000 -> req_ready[0] pulse, one fpu_valid pulse with fpu_din1/fpu_din2 matching the operands, then rsp_valid[0] with rsp_data=32'h40400000 one cycle after fpu_ready.
- Contention: all four req_valid held high with distinct operands -> accept order 0,1,2,3,0; each rsp_valid[i] carries requester i's sum; never more than one fpu_valid outstanding.
- Priority rotation: after requester 2 is served, requesters 1 and 3 request together -> requester 3 is granted first.
- Stale and withdrawn requests: fpu_ready pulsed while in IDLE -> no rsp_valid. req_valid[1] dropped before grant -> no req_ready[1].
- Reset mid-op: assert reset during WAIT_RES -> all outputs 0 immediately; after release the next request is granted to requester 0 first; no response for the dropped operation.
- Timeout (macro defined, TIMEOUT=64, adder stub never responds) -> rsp_valid[g] exactly 64 cycles after ISSUE, rsp_data=32'h7FC00000, rsp_err=1. A later fpu_ready is ignored.
